sramlike_data_responder: RTL
============================

Name: sramlike_data_responder

Overview:
SRAM-like protocol responder (slave side) for the data port driven by the execute stage: accepts req/wr/size/addr/wstrb/wdata, answers addr_ok, then returns data_ok/rdata in order. Backs onto a single-port synchronous word RAM with 1-cycle read latency. Programmable addr_ok and data_ok delays plus bounded outstanding depth, so the same RTL serves as both a real cache-less data memory front-end and a latency-stress target for pipeline verification.

Parameters:
DEPTH, 4, max outstanding accepted-but-unanswered requests (power of 2, 1..8)
ADDR_DELAY, 0, cycles req must be held high before addr_ok may assert (0 = same cycle)
DATA_DELAY, 0, extra cycles between earliest possible and actual data_ok (0 = data_ok the cycle after handshake)
RAM_AW, 16, RAM word-address width

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
data_sram_req  in  1  request valid
data_sram_wr  in  1  1 = write, 0 = read
data_sram_size  in  2  0 = byte, 1 = half, 2 = word
data_sram_addr  in  32  byte address
data_sram_wstrb  in  4  byte write enables (writes only)
data_sram_wdata  in  32  write data, already lane-aligned
data_sram_addr_ok  out  1  request accepted this cycle (handshake = req & addr_ok)
data_sram_data_ok  out  1  one-cycle pulse, oldest outstanding request complete
data_sram_rdata  out  32  full RAM word for reads; 0 for writes; valid only with data_ok
ram_en  out  1  RAM access enable
ram_we  out  4  RAM byte write enables
ram_addr  out  RAM_AW  RAM word address = data_sram_addr[RAM_AW+1:2]
ram_wdata  out  32  = data_sram_wdata
ram_rdata  in  32  RAM read data, valid the cycle after ram_en

Behaviour:
- Reset (async assert, takes effect immediately): addr_ok=0, data_ok=0, rdata=0, ram_en=0, ram_we=0; queue emptied, outstanding count=0, hold counter=0. Requests in flight at reset are dropped, never answered.
- Hold counter: increments each cycle req=1 without handshake, saturating at ADDR_DELAY. Clears on handshake or when req=0.
- addr_ok = req & (hold counter >= ADDR_DELAY) & (count < DEPTH). Combinational. No bypass when count==DEPTH, even if the head pops the same cycle.
- On handshake: ram_en=1; ram_we = wr ? wstrb : 0. Allocate tail entry {wr, data_pending=~wr, age=0}.
- Cycle after a read handshake: ram_rdata captured into that entry, data_pending cleared. Writes store data 0.
- age increments every cycle while the entry is valid, saturating at DATA_DELAY+1.
- data_ok = head valid & ~data_pending & (age >= DATA_DELAY+1); rdata = head data. The head pops on the same edge. Strictly in order; no backpressure on data_ok (master always accepts).
- Minimum latency: handshake in cycle N, data_ok in N+1+DATA_DELAY. Back-to-back handshakes give back-to-back data_ok.
- Simultaneous handshake and pop: count unchanged; tail and head pointers advance independently with wrap-around modulo DEPTH.
- size is not used for the RAM access (wstrb governs writes; reads return the whole word). size is retained for assertion checking only: word access with addr[1:0]!=0, or half access with addr[0]!=0, is illegal (simulation assertion only, no RTL response).
- Write with wstrb=0: no RAM byte changes, but the request is still accepted and gets data_ok.
- Read-after-write to the same word in consecutive handshakes returns the new data (the RAM write completes at the handshake edge).
- req dropped before addr_ok: no state change apart from the hold counter clearing.

Decomposition:
- Shared macros header: size encodings (SIZE_BYTE/HALF/WORD), the ram_addr slice macro, and entry field widths.
- One natural sub-module, sramlike_resp_queue: the DEPTH-entry in-order FIFO with per-entry age and data_pending. It exposes push, fill (1-cycle delayed), and pop with head outputs. The top level holds the hold counter, addr_ok logic, and RAM drive.

Test Plan:
- Defaults; st.w addr 0x100 wdata 0xDEADBEEF wstrb 4'b1111, then ld.w 0x100 -> addr_ok same cycle as req each time; data_ok at N+1 with rdata 0; read data_ok at M+1 with rdata 0xDEADBEEF.
- st.b addr 0x101 wdata 0x0000AA00 wstrb 4'b0010 over a word holding 0x11223344, then ld -> rdata 0x1122AA44.
- DEPTH=2, DATA_DELAY=3; 4 back-to-back reads -> addr_ok for the first 2, low for 3 cycles, then reaccepts as pops occur; data_ok order matches issue order, and the first data_ok is at handshake+4.
- ADDR_DELAY=2; req held -> addr_ok on the 3rd cycle. Drop req after 1 cycle, then re-raise -> the count restarts and addr_ok again needs 3 held cycles.
- Reset asserted asynchronously mid-clock with 3 requests outstanding -> all outputs 0 immediately, no data_ok after release, and the next request is serviced with minimum latency.
- Simultaneous handshake and pop with a full-depth wrap (issue 10 requests at DEPTH=4, DATA_DELAY=0) -> no lost or duplicated data_ok; 10 pulses, with rdata matching preloaded RAM words.

Source files
------------

// File: rtl/sramlike_data_responder_pkg.sv
// sramlike_data_responder_pkg: access size encodings and alignment rule for the data port
package sramlike_data_responder_pkg;
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  function automatic logic size_legal(input logic [1:0] size, input logic [1:0] off);
    return !((size == SIZE_WORD && off != 2'd0) || (size == SIZE_HALF && off[0]));
  endfunction
endpackage

// File: rtl/sramlike_resp_queue.sv
// sramlike_resp_queue: in-order response FIFO with per-entry age and pending read fill
module sramlike_resp_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_DELAY = 0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic        push_wr,
  input  logic [31:0] fill_data,
  input  logic        pop,
  output logic        full,
  output logic        head_ok,
  output logic [31:0] head_data
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(DATA_DELAY + 2);
  localparam logic [GW-1:0] AGE_MAX = GW'(DATA_DELAY + 1);
  logic [DEPTH-1:0] valid, pend;
  logic [GW-1:0] age [DEPTH];
  logic [31:0] data [DEPTH];
  logic [PW-1:0] head, tail, fill_idx;
  logic [CW-1:0] count;
  logic fill_vld;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction
  assign full = count == CW'(DEPTH);
  assign head_ok = valid[head] && (!pend[head] || (fill_vld && fill_idx == head)) && age[head] == AGE_MAX;
  assign head_data = pend[head] ? fill_data : data[head];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= '0;
      pend <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      fill_vld <= 1'b0;
      fill_idx <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age[i] <= '0;
        data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (valid[i] && age[i] != AGE_MAX) age[i] <= age[i] + GW'(1);
      if (fill_vld) begin
        data[fill_idx] <= fill_data;
        pend[fill_idx] <= 1'b0;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head <= nxt(head);
      end
      if (push) begin
        valid[tail] <= 1'b1;
        pend[tail] <= !push_wr;
        age[tail] <= GW'(1);
        data[tail] <= '0;
        tail <= nxt(tail);
      end
      fill_vld <= push && !push_wr;
      fill_idx <= tail;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/sramlike_data_responder.sv
// sramlike_data_responder: SRAM-like data-port slave over a 1-cycle synchronous word RAM
module sramlike_data_responder
  import sramlike_data_responder_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_DELAY = 0,
  parameter int DATA_DELAY = 0,
  parameter int RAM_AW     = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [31:0]       data_sram_addr,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [31:0]       data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [31:0]       data_sram_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);
  localparam int HW = ADDR_DELAY > 0 ? $clog2(ADDR_DELAY + 1) : 1;
  logic [HW-1:0] hold;
  logic hs, full, head_ok;
  logic [31:0] head_data;
  logic unused_addr;
  assign data_sram_addr_ok = resetn && data_sram_req && hold == HW'(ADDR_DELAY) && !full;
  assign hs = data_sram_req && data_sram_addr_ok;
  assign data_sram_data_ok = head_ok;
  assign data_sram_rdata = head_ok ? head_data : '0;
  assign ram_en = hs;
  assign ram_we = (hs && data_sram_wr) ? data_sram_wstrb : '0;
  assign ram_addr = data_sram_addr[RAM_AW+1:2];
  assign ram_wdata = data_sram_wdata;
  assign unused_addr = ^data_sram_addr[31:RAM_AW+2];
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) hold <= '0;
    else hold <= (hs || !data_sram_req) ? '0 : hold + HW'(hold != HW'(ADDR_DELAY));
  end
  sramlike_resp_queue #(
    .DEPTH(DEPTH),
    .DATA_DELAY(DATA_DELAY)
  ) u_queue (
    .clk(clk),
    .resetn(resetn),
    .push(hs),
    .push_wr(data_sram_wr),
    .fill_data(ram_rdata),
    .pop(head_ok),
    .full(full),
    .head_ok(head_ok),
    .head_data(head_data)
  );
  always_ff @(posedge clk) begin
    if (resetn && hs)
      assert (size_legal(data_sram_size, data_sram_addr[1:0]))
      else $error("misaligned data_sram access addr=%h size=%0d", data_sram_addr, data_sram_size);
  end
endmodule
